multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
Main control FSM of the multi-cycle MIPS datapath. It generates the clock-enable strobes (PC, IR) and datapath mux selects that drive the 32-bit enable registers and the register file. It also sequences memory accesses with a ready handshake. It consumes opcode/funct from the IR and the ALU zero flag, and drives the CE inputs of the PC/IR registers plus all mux/ALU controls.

Parameters:
none (encodings fixed in package)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed current read/write this cycle
pc_ce  out  1  PC register CE = pc_write | (pc_write_cond & (zero ^ is_bne))
ir_write  out  1  IR register CE
mem_read  out  1  memory read request
mem_write  out  1  memory write request
i_or_d  out  1  0: address=PC, 1: address=ALUOut
reg_write  out  1  register file write enable
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
alu_src_a  out  1  0 PC, 1 reg A
alu_src_b  out  2  00 reg B, 01 const 4, 10 ext imm, 11 sext imm<<2
ext_op  out  2  00 sign, 01 zero, 10 imm<<16
alu_ctrl  out  3  and 000, or 001, add 010, xor 011, nor 100, srl 101, sub 110, slt 111
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 reg A
illegal_op  out  1  one-cycle pulse on undecodable instruction
state  out  4  current state (debug)

Behaviour:
- States, 4-bit: IF=0, ID=1, MEM_ADDR=2, MEM_RD=3, WB_LW=4, MEM_WR=5, EX_R=6, WB_R=7, EX_BR=8, EX_J=9, EX_I=10, WB_I=11, EX_JR=12. Codes 13-15 go to IF with all strobes 0.
- Outputs are combinational from state (+mem_ready, zero, opcode). Unlisted outputs are 0 in every state.
- rst high: next state = IF. While rst is high, pc_ce, ir_write, reg_write, mem_write and illegal_op are forced to 0. After reset, outputs equal the IF decode.
- IF: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, add, pc_source=00.
  - mem_ready=1: ir_write=1, pc_ce=1, go to ID.
  - mem_ready=0: stay in IF, no strobes.
- ID: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 0x23 / 0x2B -> MEM_ADDR
  - 0x00 -> EX_R; if funct=0x08 -> EX_JR
  - 0x04 / 0x05 -> EX_BR
  - 0x02 / 0x03 -> EX_J
  - 0x08 / 0x0A / 0x0C / 0x0D / 0x0F -> EX_I
  - Otherwise, or an R-type funct not in {20,22,24,25,26,27,2A,02,08}: illegal_op=1, go to IF.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=00, add. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then -> WB_LW. MDR captures every cycle.
- WB_LW: reg_write=1, reg_dst=00, mem_to_reg=01 -> IF.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then -> IF.
- EX_R: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (20 add, 22 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 02 srl) -> WB_R.
- WB_R: reg_write=1, reg_dst=01, mem_to_reg=00 -> IF.
- EX_BR: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01. is_bne = (opcode==0x05) -> IF.
- EX_J: pc_ce=1, pc_source=10. For jal also reg_write=1, reg_dst=10, mem_to_reg=10; PC already holds PC+4 and is written on the same edge. -> IF.
- EX_JR: pc_ce=1, pc_source=11 -> IF.
- EX_I: alu_src_a=1, alu_src_b=10 -> WB_I.
  - addi: ext_op 00, add
  - slti: ext_op 00, slt
  - andi: ext_op 01, and
  - ori: ext_op 01, or
  - lui: ext_op 10, or (rs=$0 by ISA encoding)
- WB_I: reg_write=1, reg_dst=00, mem_to_reg=00 -> IF.
- CPI: lw 5, sw 4, R/I 4, branch/jump 3, each plus memory wait cycles.

Decomposition:
- Package mc_pkg: state codes, opcode/funct constants, alu_ctrl / reg_dst / mem_to_reg / alu_src_b / pc_source / ext_op encodings.
- One sub-module, alu_decoder: funct -> alu_ctrl, plus an R-type legal flag; used in EX_R and in the ID legality check.

Test Plan:
- rst=1 for 2 cycles, mem_ready=0 -> state=0, mem_read=1, pc_ce=0, ir_write=0; holds in IF for 3 cycles.
- lw (opcode 0x23), mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=01 only in state 4; total 5 cycles.
- sw with mem_ready low 3 cycles in MEM_WR -> mem_write held 4 cycles, state 5 held, then IF; reg_write never asserted.
- beq with zero=1 -> pc_ce=1 in EX_BR; beq with zero=0 -> pc_ce=0; bne with zero=0 -> pc_ce=1, pc_source=01.
- R-type funct 0x22 -> alu_ctrl=110 in EX_R, reg_dst=01 in WB_R. funct 0x3F -> illegal_op pulse in ID, next state IF, no reg_write.
- jal (0x03) -> EX_J with pc_ce=1, reg_write=1, reg_dst=10, mem_to_reg=10. rst asserted during MEM_RD -> no strobes that cycle, next state IF.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control slice.
// Contents: FSM state codes, opcode/funct constants and the encodings of
// every datapath select driven by the controller.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_LW    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EX_R     = 4'd6,
        S_WB_R     = 4'd7,
        S_EX_BR    = 4'd8,
        S_EX_J     = 4'd9,
        S_EX_I     = 4'd10,
        S_WB_I     = 4'd11,
        S_EX_JR    = 4'd12
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    // ALU operation
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Register file destination
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Register file write-data source
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // ALU B operand
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // Next-PC source
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REGA   = 2'b11;

    // Immediate extension
    localparam logic [1:0] EXT_SIGN = 2'b00;
    localparam logic [1:0] EXT_ZERO = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle.
// master: the control FSM (consumes opcode/funct/zero/mem_ready, drives
//         strobes, selects and debug state).
// slave : the datapath / memory side.
interface multi_cycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_ce;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ext_op;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_ce, ir_write, mem_read, mem_write, i_or_d, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op,
               alu_ctrl, pc_source, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_ce, ir_write, mem_read, mem_write, i_or_d, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op,
               alu_ctrl, pc_source, illegal_op, state
    );
endinterface

// File: rtl/multi_cycle_ctrl_alu_decoder.sv
// R-type funct decoder.
// funct_i    : IR[5:0]
// alu_ctrl_o : ALU operation for the funct (add when not an ALU op)
// legal_o    : funct is one of the supported R-type instructions (incl. jr)
module alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       legal_o
);
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b1;
        case (funct_i)
            F_ADD:   alu_ctrl_o = ALU_ADD;
            F_SUB:   alu_ctrl_o = ALU_SUB;
            F_AND:   alu_ctrl_o = ALU_AND;
            F_OR:    alu_ctrl_o = ALU_OR;
            F_XOR:   alu_ctrl_o = ALU_XOR;
            F_NOR:   alu_ctrl_o = ALU_NOR;
            F_SLT:   alu_ctrl_o = ALU_SLT;
            F_SRL:   alu_ctrl_o = ALU_SRL;
            F_JR:    alu_ctrl_o = ALU_ADD;   // legal, but handled by EX_JR
            default: legal_o    = 1'b0;
        endcase
    end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath.
// clk : system clock
// rst : synchronous active-high reset
// bus : controller side (master) of multi_cycle_ctrl_if -- IR fields, zero
//       flag and memory ready in; CE strobes, mux/ALU selects, illegal_op
//       pulse and debug state out.
// Outputs are a combinational decode of the current state (plus mem_ready,
// zero and opcode where an instruction needs them).
module multi_cycle_ctrl
    import mc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    multi_cycle_ctrl_if.master bus
);
    state_t     state_q, state_d;
    logic [2:0] dec_alu_ctrl;
    logic       dec_legal;

    logic       pc_write, pc_write_cond, is_bne;
    logic       ir_write, mem_read, mem_write, i_or_d, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, ext_op, pc_source;
    logic       alu_src_a, illegal_op;
    logic [2:0] alu_ctrl;

    alu_decoder u_alu_decoder (
        .funct_i    (bus.funct),
        .alu_ctrl_o (dec_alu_ctrl),
        .legal_o    (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        is_bne        = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = RD_RT;
        mem_to_reg    = M2R_ALUOUT;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        ext_op        = EXT_SIGN;
        alu_ctrl      = ALU_AND;
        pc_source     = PCS_ALU;
        illegal_op    = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ctrl  = ALU_ADD;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                // Branch target computed speculatively into ALUOut.
                alu_src_b = SRCB_BOFF;
                alu_ctrl  = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (!dec_legal) begin
                            illegal_op = 1'b1;
                            state_d    = S_IF;
                        end else if (bus.funct == F_JR) begin
                            state_d = S_EX_JR;
                        end else begin
                            state_d = S_EX_R;
                        end
                    end
                    OP_BEQ, OP_BNE: state_d = S_EX_BR;
                    OP_J, OP_JAL:   state_d = S_EX_J;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:
                                    state_d = S_EX_I;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_IF;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_op    = EXT_SIGN;
                alu_ctrl  = ALU_ADD;
                state_d   = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (bus.mem_ready) state_d = S_WB_LW;
            end
            S_WB_LW: begin
                reg_write  = 1'b1;
                reg_dst    = RD_RT;
                mem_to_reg = M2R_MDR;
                state_d    = S_IF;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (bus.mem_ready) state_d = S_IF;
            end
            S_EX_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_ctrl  = dec_alu_ctrl;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = RD_RD;
                mem_to_reg = M2R_ALUOUT;
                state_d    = S_IF;
            end
            S_EX_BR: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REG;
                alu_ctrl      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCS_ALUOUT;
                is_bne        = (bus.opcode == OP_BNE);
                state_d       = S_IF;
            end
            S_EX_J: begin
                pc_write  = 1'b1;
                pc_source = PCS_JUMP;
                // PC still holds PC+4 here, so the link value is written on
                // the same edge that loads the jump target.
                if (bus.opcode == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = RD_RA;
                    mem_to_reg = M2R_PC;
                end
                state_d = S_IF;
            end
            S_EX_JR: begin
                pc_write  = 1'b1;
                pc_source = PCS_REGA;
                state_d   = S_IF;
            end
            S_EX_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_SLTI: begin ext_op = EXT_SIGN; alu_ctrl = ALU_SLT; end
                    OP_ANDI: begin ext_op = EXT_ZERO; alu_ctrl = ALU_AND; end
                    OP_ORI:  begin ext_op = EXT_ZERO; alu_ctrl = ALU_OR;  end
                    // lui: rs is $0, so OR passes the shifted immediate.
                    OP_LUI:  begin ext_op = EXT_LUI;  alu_ctrl = ALU_OR;  end
                    default: begin ext_op = EXT_SIGN; alu_ctrl = ALU_ADD; end
                endcase
                state_d = S_WB_I;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                reg_dst    = RD_RT;
                mem_to_reg = M2R_ALUOUT;
                state_d    = S_IF;
            end
            default: state_d = S_IF;  // unused codes recover with no strobes
        endcase

        // Reset suppresses every state-changing strobe for that cycle.
        if (rst) begin
            state_d       = S_IF;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            illegal_op    = 1'b0;
        end
    end

    assign bus.pc_ce      = pc_write | (pc_write_cond & (bus.zero ^ is_bne));
    assign bus.ir_write   = ir_write;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.i_or_d     = i_or_d;
    assign bus.reg_write  = reg_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.ext_op     = ext_op;
    assign bus.alu_ctrl   = alu_ctrl;
    assign bus.pc_source  = pc_source;
    assign bus.illegal_op = illegal_op;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: each step drives inputs, queues the
// expected output snapshot, and checks it against the DUT mid-cycle.
module tb_multi_cycle_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pc_ce;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       illegal;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_source;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [3:0] st, input logic pc, ir, mrd, mwr, rw, ill,
                                input logic [1:0] rdst, m2r, input logic [2:0] alu,
                                input logic [1:0] pcs);
        exp_t e;
        e.st = st; e.pc_ce = pc; e.ir_write = ir; e.mem_read = mrd; e.mem_write = mwr;
        e.reg_write = rw; e.illegal = ill; e.reg_dst = rdst; e.mem_to_reg = m2r;
        e.alu_ctrl = alu; e.pc_source = pcs;
        return e;
    endfunction

    task automatic cyc(input string tag, input logic r, mr, z,
                       input logic [5:0] op, fn, input exp_t e);
        exp_t obs, want;
        @(negedge clk);
        rst = r; bus.mem_ready = mr; bus.zero = z; bus.opcode = op; bus.funct = fn;
        sb.push_back(e);
        #1;
        obs = mk(bus.state, bus.pc_ce, bus.ir_write, bus.mem_read, bus.mem_write,
                 bus.reg_write, bus.illegal_op, bus.reg_dst, bus.mem_to_reg,
                 bus.alu_ctrl, bus.pc_source);
        want = sb.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
        $display("step %-12s state=%0d obs=%h exp=%h", tag, bus.state, obs, want);
    endtask

    initial begin
        rst = 1'b1; bus.mem_ready = 1'b0; bus.zero = 1'b0;
        bus.opcode = 6'h00; bus.funct = 6'h00;
        @(posedge clk);

        // Reset: IF decode visible, strobes forced low even with mem_ready.
        cyc("rst0",     1, 0, 0, 6'h00, 6'h00, mk(0, 0,0,1,0,0,0, 0,0,3'b010,0));
        cyc("rst1_rdy", 1, 1, 0, 6'h00, 6'h00, mk(0, 0,0,1,0,0,0, 0,0,3'b010,0));
        for (int i = 0; i < 3; i++)
            cyc("if_hold",  0, 0, 0, 6'h00, 6'h00, mk(0, 0,0,1,0,0,0, 0,0,3'b010,0));

        // lw, memory always ready: 0,1,2,3,4
        cyc("lw_if",    0, 1, 0, 6'h23, 6'h00, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("lw_id",    0, 1, 0, 6'h23, 6'h00, mk(1, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("lw_addr",  0, 1, 0, 6'h23, 6'h00, mk(2, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("lw_rd",    0, 1, 0, 6'h23, 6'h00, mk(3, 0,0,1,0,0,0, 0,0,3'b000,0));
        cyc("lw_wb",    0, 1, 0, 6'h23, 6'h00, mk(4, 0,0,0,0,1,0, 0,1,3'b000,0));

        // sw with three wait cycles in MEM_WR
        cyc("sw_if",    0, 1, 0, 6'h2B, 6'h00, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("sw_id",    0, 1, 0, 6'h2B, 6'h00, mk(1, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("sw_addr",  0, 1, 0, 6'h2B, 6'h00, mk(2, 0,0,0,0,0,0, 0,0,3'b010,0));
        for (int i = 0; i < 3; i++)
            cyc("sw_wait",  0, 0, 0, 6'h2B, 6'h00, mk(5, 0,0,0,1,0,0, 0,0,3'b000,0));
        cyc("sw_wr",    0, 1, 0, 6'h2B, 6'h00, mk(5, 0,0,0,1,0,0, 0,0,3'b000,0));

        // beq taken / not taken, bne taken / not taken
        cyc("beq1_if",  0, 1, 0, 6'h04, 6'h00, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("beq1_id",  0, 1, 0, 6'h04, 6'h00, mk(1, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("beq_z1",   0, 1, 1, 6'h04, 6'h00, mk(8, 1,0,0,0,0,0, 0,0,3'b110,1));
        cyc("beq0_if",  0, 1, 0, 6'h04, 6'h00, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("beq0_id",  0, 1, 0, 6'h04, 6'h00, mk(1, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("beq_z0",   0, 1, 0, 6'h04, 6'h00, mk(8, 0,0,0,0,0,0, 0,0,3'b110,1));
        cyc("bne0_if",  0, 1, 0, 6'h05, 6'h00, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("bne0_id",  0, 1, 0, 6'h05, 6'h00, mk(1, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("bne_z0",   0, 1, 0, 6'h05, 6'h00, mk(8, 1,0,0,0,0,0, 0,0,3'b110,1));
        cyc("bne1_if",  0, 1, 1, 6'h05, 6'h00, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("bne1_id",  0, 1, 1, 6'h05, 6'h00, mk(1, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("bne_z1",   0, 1, 1, 6'h05, 6'h00, mk(8, 0,0,0,0,0,0, 0,0,3'b110,1));

        // R-type sub
        cyc("sub_if",   0, 1, 0, 6'h00, 6'h22, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("sub_id",   0, 1, 0, 6'h00, 6'h22, mk(1, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("sub_ex",   0, 1, 0, 6'h00, 6'h22, mk(6, 0,0,0,0,0,0, 0,0,3'b110,0));
        cyc("sub_wb",   0, 1, 0, 6'h00, 6'h22, mk(7, 0,0,0,0,1,0, 1,0,3'b000,0));

        // Illegal funct, then illegal opcode
        cyc("ilf_if",   0, 1, 0, 6'h00, 6'h3F, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("ilf_id",   0, 1, 0, 6'h00, 6'h3F, mk(1, 0,0,0,0,0,1, 0,0,3'b010,0));
        cyc("ilf_back", 0, 1, 0, 6'h3F, 6'h00, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("ilo_id",   0, 0, 0, 6'h3F, 6'h00, mk(1, 0,0,0,0,0,1, 0,0,3'b010,0));
        cyc("ilo_back", 0, 0, 0, 6'h3F, 6'h00, mk(0, 0,0,1,0,0,0, 0,0,3'b010,0));

        // jal, j, jr
        cyc("jal_if",   0, 1, 0, 6'h03, 6'h00, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("jal_id",   0, 1, 0, 6'h03, 6'h00, mk(1, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("jal_ex",   0, 1, 0, 6'h03, 6'h00, mk(9, 1,0,0,0,1,0, 2,2,3'b000,2));
        cyc("j_if",     0, 1, 0, 6'h02, 6'h00, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("j_id",     0, 1, 0, 6'h02, 6'h00, mk(1, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("j_ex",     0, 1, 0, 6'h02, 6'h00, mk(9, 1,0,0,0,0,0, 0,0,3'b000,2));
        cyc("jr_if",    0, 1, 0, 6'h00, 6'h08, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("jr_id",    0, 1, 0, 6'h00, 6'h08, mk(1, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("jr_ex",    0, 1, 0, 6'h00, 6'h08, mk(12,1,0,0,0,0,0, 0,0,3'b000,3));

        // ori
        cyc("ori_if",   0, 1, 0, 6'h0D, 6'h00, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("ori_id",   0, 1, 0, 6'h0D, 6'h00, mk(1, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("ori_ex",   0, 1, 0, 6'h0D, 6'h00, mk(10,0,0,0,0,0,0, 0,0,3'b001,0));
        cyc("ori_wb",   0, 1, 0, 6'h0D, 6'h00, mk(11,0,0,0,0,1,0, 0,0,3'b000,0));

        // Reset asserted while in MEM_RD
        cyc("lwr_if",   0, 1, 0, 6'h23, 6'h00, mk(0, 1,1,1,0,0,0, 0,0,3'b010,0));
        cyc("lwr_id",   0, 1, 0, 6'h23, 6'h00, mk(1, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("lwr_addr", 0, 1, 0, 6'h23, 6'h00, mk(2, 0,0,0,0,0,0, 0,0,3'b010,0));
        cyc("lwr_rst",  1, 1, 0, 6'h23, 6'h00, mk(3, 0,0,1,0,0,0, 0,0,3'b000,0));
        cyc("lwr_if2",  0, 0, 0, 6'h23, 6'h00, mk(0, 0,0,1,0,0,0, 0,0,3'b010,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
